// File: rtl/matrix_fill_stream.sv
`default_nettype none
// =============================================================================
// matrix_fill_stream : streams packed beats into a ROWS x COLS tile, optional transpose
// Revision: 1.0
// =============================================================================
module matrix_fill_stream #(
  parameter int DATA_W     = 4,
  parameter int ROWS       = 2,
  parameter int COLS       = 4,
  parameter int BEAT_ELEMS = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [BEAT_ELEMS*DATA_W-1:0]      in_data_i,
  input  logic                              in_transpose_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [ROWS*COLS*DATA_W-1:0]       out_data_o,
  output logic                              out_transposed_o,
  output logic [15:0]                       tiles_done_o
);

  localparam int c_N      = ROWS * COLS;
  localparam int c_BEATS  = c_N / BEAT_ELEMS;
  localparam int c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_BEAT_W = BEAT_ELEMS * DATA_W;
  localparam int c_TILE_W = c_N * DATA_W;
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

  localparam logic [0:0] c_ST_FILL = 1'b0;
  localparam logic [0:0] c_ST_FULL = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [c_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                mode_q, mode_d;
  logic [15:0]         tiles_q, tiles_d;
  logic [c_TILE_W-1:0] storage_q;
  logic [c_TILE_W-1:0] w_trans;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_last_beat;

  // clear wins over both handshakes in the same cycle
  assign w_in_fire   = in_valid_i & in_ready_q & ~clear_i;
  assign w_out_fire  = out_valid_q & out_ready_i & ~clear_i;
  assign w_last_beat = (beat_cnt_q == c_LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_ST_FILL;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (clear_i) begin
      state_d    = c_ST_FILL;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        c_ST_FILL: begin
          if (w_in_fire) begin
            if (w_last_beat) begin
              beat_cnt_d = '0;
              state_d    = c_ST_FULL;
            end else begin
              beat_cnt_d = beat_cnt_q + c_CNT_W'(1);
            end
          end
        end
        c_ST_FULL: begin
          if (w_out_fire) state_d = c_ST_FILL;
        end
        default: state_d = c_ST_FILL;
      endcase
    end
  end

  // Handshake outputs are registered from the next state to avoid comb paths
  always_comb begin
    in_ready_d  = (state_d == c_ST_FILL);
    out_valid_d = (state_d == c_ST_FULL);
  end

  always_comb begin
    mode_d  = (w_in_fire && (beat_cnt_q == '0)) ? in_transpose_i : mode_q;
    tiles_d = tiles_q + {15'd0, w_out_fire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 1'b0;
      tiles_q   <= '0;
      storage_q <= '0;
    end else begin
      mode_q  <= mode_d;
      tiles_q <= tiles_d;
      for (int b = 0; b < c_BEATS; b++) begin
        if (w_in_fire && (beat_cnt_q == c_CNT_W'(b)))
          storage_q[b*c_BEAT_W +: c_BEAT_W] <= in_data_i;
      end
    end
  end

  // Transposed view: output (r',c') of the COLS x ROWS tile is native (c',r')
  for (genvar r = 0; r < COLS; r++) begin : g_trow
    for (genvar c = 0; c < ROWS; c++) begin : g_tcol
      assign w_trans[(r*ROWS+c)*DATA_W +: DATA_W] = storage_q[(c*COLS+r)*DATA_W +: DATA_W];
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = out_valid_q;
  assign out_data_o       = mode_q ? w_trans : storage_q;
  assign out_transposed_o = mode_q;
  assign tiles_done_o     = tiles_q;

endmodule
`default_nettype wire
